keypad_scanner: RTL and testbench

//  Producer end of the alarm clock's key[3:0] entry interface. Scans a 4x3 matrix keypad.

---
 rtl/keypad_scanner_pkg.sv | 36 +++
 rtl/keypad_scanner_debounce.sv | 56 +++++
 rtl/keypad_scanner.sv | 103 ++++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Key codes and the 4x3 keypad map, shared by the keypad scanner and the alarm clock top.
package alarmclock_defs;

    localparam logic [3:0] KEY_NOKEY = 4'd10;
    localparam logic [3:0] KEY_STAR  = 4'd11;
    localparam logic [3:0] KEY_HASH  = 4'd12;

    localparam logic [3:0] KEY_MAP [4][3] = '{
        '{4'd1,     4'd2, 4'd3},
        '{4'd4,     4'd5, 4'd6},
        '{4'd7,     4'd8, 4'd9},
        '{KEY_STAR, 4'd0, KEY_HASH}
    };

    function automatic logic [1:0] active_cols(input logic [2:0] cols_n);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < 3; i++) begin
            n = n + {1'b0, ~cols_n[i]};
        end
        return n;
    endfunction

    // Index of the pulled-low column; only meaningful when exactly one is low.
    function automatic logic [1:0] active_col_idx(input logic [2:0] cols_n);
        logic [1:0] idx;
        case (cols_n)
            3'b110:  idx = 2'd0;
            3'b101:  idx = 2'd1;
            3'b011:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Frame-level debouncer: accepts a frame result only after DEBOUNCE_SCANS identical frames.
module keypad_debounce
    import alarmclock_defs::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [3:0] frame_result,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       cand;
    logic [CNT_W-1:0] stable_cnt;

    // Candidate tracking on frame ends, acceptance on the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cand       <= KEY_NOKEY;
            stable_cnt <= '0;
            key        <= KEY_NOKEY;
            key_strobe <= 1'b0;
        end else begin
            if (frame_valid) begin
                if (frame_result == cand) begin
                    if (stable_cnt != CNT_MAX) begin
                        stable_cnt <= stable_cnt + CNT_W'(1);
                    end else begin
                        stable_cnt <= stable_cnt;
                    end
                end else begin
                    cand       <= frame_result;
                    stable_cnt <= CNT_W'(1);
                end
            end else begin
                cand       <= cand;
                stable_cnt <= stable_cnt;
            end

            // Releases update key silently; only real keys pulse the strobe.
            if ((stable_cnt == CNT_MAX) && (cand != key)) begin
                key        <= cand;
                key_strobe <= (cand != KEY_NOKEY);
            end else begin
                key        <= key;
                key_strobe <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row walking, column sampling, per-frame ghost-rejecting decode.
module keypad_scanner
    import alarmclock_defs::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       hit_cnt;
    logic [3:0]       hit_code;

    logic       slot_end;
    logic       frame_end;
    logic [1:0] n_act;
    logic [1:0] act_col;
    logic [1:0] next_row;
    logic [1:0] hit_cnt_next;
    logic [3:0] hit_code_next;
    logic [3:0] frame_result;

    // Fold the current row sample into the frame accumulators; hit_cnt saturates at 2.
    always_comb begin
        slot_end      = (div_cnt == DIV_LAST);
        frame_end     = slot_end && (row_idx == 2'd3);
        n_act         = active_cols(col_n);
        act_col       = active_col_idx(col_n);
        next_row      = row_idx + 2'd1;
        hit_cnt_next  = hit_cnt;
        hit_code_next = hit_code;
        if (slot_end) begin
            if (({1'b0, hit_cnt} + {1'b0, n_act}) >= 3'd2) begin
                hit_cnt_next = 2'd2;
            end else begin
                hit_cnt_next = hit_cnt + n_act;
            end
            if (n_act == 2'd1) begin
                hit_code_next = KEY_MAP[row_idx][act_col];
            end else begin
                hit_code_next = hit_code;
            end
        end else begin
            hit_cnt_next  = hit_cnt;
            hit_code_next = hit_code;
        end
        if (hit_cnt_next == 2'd1) begin
            frame_result = hit_code_next;
        end else begin
            frame_result = KEY_NOKEY;
        end
    end

    // Row scan counter, row driver and frame accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt  <= '0;
            row_idx  <= 2'd0;
            row_n    <= 4'b1110;
            hit_cnt  <= 2'd0;
            hit_code <= KEY_NOKEY;
        end else begin
            if (slot_end) begin
                div_cnt <= '0;
                row_idx <= next_row;
                row_n   <= ~(4'b0001 << next_row);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
                row_idx <= row_idx;
                row_n   <= row_n;
            end
            if (frame_end) begin
                hit_cnt  <= 2'd0;
                hit_code <= KEY_NOKEY;
            end else begin
                hit_cnt  <= hit_cnt_next;
                hit_code <= hit_code_next;
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .frame_valid (frame_end),
        .frame_result(frame_result),
        .key         (key),
        .key_strobe  (key_strobe)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: frame-aligned key patterns against a frame-level reference model.
module tb_keypad_scanner;

    localparam int FRAME = 16;
    localparam int DEB   = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key;
    logic       key_strobe;

    logic [11:0] pressed = 12'd0;   // bit r*3+c = key at row r, column c held down

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] key;
        logic       strobe;
        int         when;
    } exp_t;

    exp_t       expq[$];
    int         results[$];
    logic [3:0] model_key = 4'd10;
    int         frame_idx = 0;
    int         since_rst = -1;
    logic [3:0] prev_key  = 4'd10;

    logic [3:0] codes [12];

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .key       (key),
        .key_strobe(key_strobe)
    );

    always #5 clock = ~clock;

    // Matrix model: a column reads low when a pressed key sits on a row driven low.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, since_rst);
        end
    endtask

    function automatic logic [3:0] frame_res(input logic [11:0] m);
        if ($countones(m) == 1) begin
            for (int i = 0; i < 12; i++) if (m[i]) return codes[i];
        end
        return 4'd10;
    endfunction

    // One scan frame with a fixed set of pressed keys; the model decides if key must change.
    task automatic run_frame(input logic [11:0] m);
        logic [3:0] r;
        pressed = m;
        r = frame_res(m);
        results.push_back(r);
        if (results.size() > DEB) void'(results.pop_front());
        if (results.size() == DEB && results[0] == results[1] && results[1] == results[2]
            && r != model_key) begin
            model_key = r;
            expq.push_back('{key: r, strobe: (r != 4'd10), when: FRAME*frame_idx + 17});
        end
        frame_idx++;
        repeat (FRAME) @(posedge clock);
        #1;
    endtask

    task automatic run_frames(input logic [11:0] m, input int n);
        for (int i = 0; i < n; i++) run_frame(m);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        reset = 1'b0;
        check("pending_at_reset", expq.size(), 0);
        expq.delete();
        results.delete();
        model_key = 4'd10;
        frame_idx = 0;
        check("reset_key", key, 4'd10);
        check("reset_strobe", key_strobe, 1'b0);
        check("reset_row_n", row_n, 4'b1110);
    endtask

    // Monitor: row walk every cycle, and every key change or strobe against the scoreboard.
    always @(negedge clock) begin
        logic [3:0] exp_row;
        exp_t e;
        if (reset) begin
            since_rst = -1;
            prev_key  = 4'd10;
        end else begin
            since_rst++;
            exp_row = ~(4'b0001 << ((since_rst / 4) % 4));
            check("row_walk", row_n, exp_row);
            if (key !== prev_key || key_strobe !== 1'b0) begin
                if (expq.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_event: key=%0d strobe=%0b at cycle %0d, no change expected",
                             key, key_strobe, since_rst);
                end else begin
                    e = expq.pop_front();
                    check("event_key", key, e.key);
                    check("event_strobe", key_strobe, e.strobe);
                    check("event_cycle", since_rst, e.when);
                end
                prev_key = key;
            end
        end
    end

    initial begin
        logic [11:0] m;
        logic [11:0] prev_m;
        int a;
        int b;
        codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd0, 4'd12};

        @(posedge clock);
        #1;
        do_reset(5);

        // '1' held then released
        run_frames(12'b0000_0000_0001, 4);
        run_frames(12'd0, 4);

        // '5' toggling, then held
        for (int i = 0; i < 2; i++) begin
            run_frame(12'b0000_0001_0000);
            run_frame(12'd0);
        end
        run_frames(12'b0000_0001_0000, 4);
        run_frames(12'd0, 4);

        // '2' and '8' together: ghost rejected
        run_frames(12'b0000_1000_0010, 6);
        run_frames(12'd0, 1);

        // '0' interrupted by a mid-frame reset
        run_frames(12'b0100_0000_0000, 2);
        repeat (7) @(posedge clock);
        #1;
        do_reset(1);
        run_frames(12'b0100_0000_0000, 4);
        run_frames(12'd0, 4);

        // '#' then direct change to '6', then '*'
        run_frames(12'b1000_0000_0000, 4);
        run_frames(12'b0000_0010_0000, 4);
        run_frames(12'b0010_0000_0000, 4);
        run_frames(12'd0, 4);

        // Randomised holds, releases and ghost pairs
        prev_m = 12'd0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: m = 12'd0;
                1, 2: m = prev_m;
                default: begin
                    a = $urandom_range(0, 11);
                    m = 12'd0;
                    m[a] = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        b = (a + $urandom_range(1, 11)) % 12;
                        m[b] = 1'b1;
                    end
                end
            endcase
            run_frame(m);
            prev_m = m;
        end
        run_frames(12'd0, 4);

        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
